// File: rtl/interface_hcsr04.sv
// HC-SR04 ultrasonic ranger interface: issues the trigger pulse, times the echo
// and reports the distance as 3-digit BCD centimetres with a one-cycle pronto strobe.
module interface_hcsr04 #(
  parameter int unsigned CLK_PER_CM     = 2941,
  parameter int unsigned HALF_CM        = 1470,
  parameter int unsigned TRIGGER_CYCLES = 500
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        medir,
  input  logic        echo,
  output logic        trigger,
  output logic [11:0] medida,
  output logic        pronto,
  output logic [3:0]  db_estado
);

  localparam int unsigned CW = $clog2(CLK_PER_CM);
  localparam int unsigned TW = $clog2(TRIGGER_CYCLES);
  localparam logic [CW-1:0] CYC_LAST  = CW'(CLK_PER_CM - 1);
  localparam logic [CW-1:0] HALF_V    = CW'(HALF_CM);
  localparam logic [TW-1:0] TRIG_LAST = TW'(TRIGGER_CYCLES - 1);

  typedef enum logic [3:0] {
    INICIAL       = 4'h0,
    PREPARACAO    = 4'h1,
    ENVIA_TRIGGER = 4'h2,
    ESPERA_ECHO   = 4'h3,
    MEDIDA        = 4'h4,
    ARMAZENAMENTO = 4'h5,
    FINAL_MEDIDA  = 4'hF
  } state_t;

  // Handshake: medir is a level request, acted on only at its rising edge while
  // idle; pronto is a single-cycle strobe, and medida is valid from that cycle on.

  state_t        state_q, state_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [11:0]   bcd_q, bcd_d;
  logic [TW-1:0] trig_cnt_q, trig_cnt_d;
  logic [11:0]   medida_q, medida_d;
  logic          trigger_q, trigger_d;
  logic          pronto_q, pronto_d;
  logic          medir_q;
  logic          echo_s1_q, echo_s2_q;
  logic          medir_rise;

  // Saturating BCD increment with decade ripple carry.
  function automatic logic [11:0] bcd_inc(input logic [11:0] v);
    logic [11:0] r;
    r = v;
    if (v != 12'h999) begin
      if (v[3:0] != 4'd9) begin
        r[3:0] = v[3:0] + 4'd1;
      end else begin
        r[3:0] = 4'd0;
        if (v[7:4] != 4'd9) begin
          r[7:4] = v[7:4] + 4'd1;
        end else begin
          r[7:4]  = 4'd0;
          r[11:8] = v[11:8] + 4'd1;
        end
      end
    end
    return r;
  endfunction

  assign medir_rise = medir & ~medir_q;

  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    bcd_d      = bcd_q;
    trig_cnt_d = trig_cnt_q;
    medida_d   = medida_q;
    case (state_q)
      INICIAL: begin
        if (medir_rise) state_d = PREPARACAO;
      end
      PREPARACAO: begin
        cyc_d      = '0;
        bcd_d      = 12'h000;
        trig_cnt_d = '0;
        state_d    = ENVIA_TRIGGER;
      end
      ENVIA_TRIGGER: begin
        if (trig_cnt_q == TRIG_LAST) state_d = ESPERA_ECHO;
        else                         trig_cnt_d = trig_cnt_q + 1'b1;
      end
      ESPERA_ECHO: begin
        if (echo_s2_q) state_d = MEDIDA;
      end
      MEDIDA: begin
        if (echo_s2_q) begin
          if (cyc_q == CYC_LAST) begin
            cyc_d = '0;
            bcd_d = bcd_inc(bcd_q);
          end else begin
            cyc_d = cyc_q + 1'b1;
          end
        end else begin
          state_d = ARMAZENAMENTO;
        end
      end
      ARMAZENAMENTO: begin
        // Round half up on the leftover fraction of a centimetre.
        medida_d = (cyc_q >= HALF_V) ? bcd_inc(bcd_q) : bcd_q;
        state_d  = FINAL_MEDIDA;
      end
      FINAL_MEDIDA: begin
        state_d = INICIAL;
      end
      default: begin
        state_d = INICIAL;
      end
    endcase
    trigger_d = (state_d == ENVIA_TRIGGER);
    pronto_d  = (state_d == FINAL_MEDIDA);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= INICIAL;
      cyc_q      <= '0;
      bcd_q      <= 12'h000;
      trig_cnt_q <= '0;
      medida_q   <= 12'h000;
      trigger_q  <= 1'b0;
      pronto_q   <= 1'b0;
      medir_q    <= 1'b0;
      echo_s1_q  <= 1'b0;
      echo_s2_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      bcd_q      <= bcd_d;
      trig_cnt_q <= trig_cnt_d;
      medida_q   <= medida_d;
      trigger_q  <= trigger_d;
      pronto_q   <= pronto_d;
      medir_q    <= medir;
      echo_s1_q  <= echo;
      echo_s2_q  <= echo_s1_q;
    end
  end

  assign trigger   = trigger_q;
  assign pronto    = pronto_q;
  assign medida    = medida_q;
  assign db_estado = state_q;

endmodule

// File: tb/tb_interface_hcsr04.sv
// Directed bench for interface_hcsr04, scaled to 29 clocks per cm so that every
// case, including saturation above 999 cm, runs in a short simulation.
module tb_interface_hcsr04;

  logic        clock;
  logic        reset;
  logic        medir;
  logic        echo;
  logic        trigger;
  logic [11:0] medida;
  logic        pronto;
  logic [3:0]  db_estado;

  int n_vec;
  int n_miss;

  interface_hcsr04 #(
    .CLK_PER_CM    (29),
    .HALF_CM       (14),
    .TRIGGER_CYCLES(500)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .medir    (medir),
    .echo     (echo),
    .trigger  (trigger),
    .medida   (medida),
    .pronto   (pronto),
    .db_estado(db_estado)
  );

  initial clock = 1'b0;
  always #10 clock = ~clock;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Raises medir for 5 cycles and checks the trigger pulse and state walk.
  task automatic start_meas(input string tag);
    int first_hi;
    int hi_cnt;
    logic [3:0] db1;
    logic [3:0] db2;
    first_hi = -1;
    hi_cnt   = 0;
    db1      = 4'h0;
    db2      = 4'h0;
    medir    = 1'b1;
    for (int k = 1; k <= 700; k++) begin
      @(negedge clock);
      if (k == 1) db1 = db_estado;
      if (k == 2) db2 = db_estado;
      if (k == 5) medir = 1'b0;
      if (trigger) begin
        hi_cnt++;
        if (first_hi < 0) first_hi = k;
      end else if (first_hi >= 0) begin
        break;
      end
    end
    medir = 1'b0;
    check({tag, " db_prep"}, 16'(db1), 16'h1);
    check({tag, " db_trig"}, 16'(db2), 16'h2);
    check({tag, " trig_width"}, 16'(hi_cnt), 16'd500);
    check({tag, " trig_start"}, 16'(first_hi >= 1 && first_hi <= 3), 16'h1);
    check({tag, " db_wait"}, 16'(db_estado), 16'h3);
  endtask

  task automatic echo_pulse(input int w);
    repeat (20) @(negedge clock);
    echo = 1'b1;
    repeat (w) @(negedge clock);
    echo = 1'b0;
  endtask

  task automatic finish_meas(input string tag, input logic [11:0] exp, input logic [11:0] prev);
    int n_pronto;
    logic [11:0] got;
    n_pronto = 0;
    got      = 12'hxxx;
    check({tag, " hold"}, 16'(medida), 16'(prev));
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (pronto) begin
        n_pronto++;
        if (n_pronto == 1) got = medida;
      end
    end
    check({tag, " pronto_once"}, 16'(n_pronto), 16'h1);
    check({tag, " medida"}, 16'(got), 16'(exp));
    check({tag, " idle"}, 16'(db_estado), 16'h0);
  endtask

  task automatic measure(input string tag, input int w, input logic [11:0] exp);
    logic [11:0] prev;
    prev = medida;
    start_meas(tag);
    echo_pulse(w);
    finish_meas(tag, exp, prev);
  endtask

  initial begin
    int n_pronto;
    logic [11:0] prev;
    n_vec  = 0;
    n_miss = 0;
    reset  = 1'b1;
    medir  = 1'b0;
    echo   = 1'b0;
    repeat (100) @(negedge clock);
    reset = 1'b0;
    repeat (5000) @(negedge clock);
    check("idle trigger", 16'(trigger), 16'h0);
    check("idle pronto", 16'(pronto), 16'h0);
    check("idle medida", 16'(medida), 16'h000);
    check("idle db", 16'(db_estado), 16'h0);

    // Echo width W gives W-1 counted cycles; 29 cycles per cm, round at 14.
    measure("w296", 296, 12'h010);
    measure("w282", 282, 12'h010);
    measure("w449", 449, 12'h015);
    measure("w450", 450, 12'h016);
    measure("w726", 726, 12'h025);
    measure("w30", 30, 12'h001);
    measure("w15", 15, 12'h001);
    measure("w14", 14, 12'h000);
    measure("w572", 572, 12'h020);
    measure("w2892", 2892, 12'h100);

    // Reset in the middle of echo timing.
    start_meas("rst");
    repeat (20) @(negedge clock);
    echo = 1'b1;
    repeat (100) @(negedge clock);
    check("rst db_medida", 16'(db_estado), 16'h4);
    reset = 1'b1;
    #1;
    check("rst db", 16'(db_estado), 16'h0);
    check("rst trigger", 16'(trigger), 16'h0);
    check("rst medida", 16'(medida), 16'h000);
    check("rst pronto", 16'(pronto), 16'h0);
    echo = 1'b0;
    repeat (5) @(negedge clock);
    reset    = 1'b0;
    n_pronto = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clock);
      if (pronto) n_pronto++;
    end
    check("rst no_pronto", 16'(n_pronto), 16'h0);
    measure("post_rst", 296, 12'h010);

    // medir edge while waiting for echo is ignored.
    prev = medida;
    start_meas("ign");
    repeat (5) @(negedge clock);
    medir = 1'b1;
    repeat (3) @(negedge clock);
    check("ign db", 16'(db_estado), 16'h3);
    medir = 1'b0;
    echo_pulse(450);
    finish_meas("ign", 12'h016, prev);

    measure("sat", 29050, 12'h999);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
